// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a small host-side byte FIFO and
// cts flow control. All state advances on the falling edge of the 16x
// bit-rate clock; reset_b clears everything asynchronously.
module uart_tx #(
    parameter int TICKS_PER_BIT = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 1
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [7:0] host_din,
    input  logic       host_wr,
    output logic       host_dir,
    input  logic       cts,
    output logic       serout,
    output logic       busy
);

    // The tick counter must reach the longest phase, which is the stop
    // period when two stop bits are configured.
    localparam int TICK_W = $clog2(TICKS_PER_BIT * STOP_BITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(TICKS_PER_BIT * STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BIT,
        STOP
    } state_t;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick;
    logic [2:0]         r_bitIdx;
    logic [7:0]         r_shift;
    logic               r_serout;
    logic               r_ctsMeta;
    logic               r_ctsSync;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    state_t             w_nextState;
    logic [TICK_W-1:0]  w_nextTick;
    logic [2:0]         w_nextBitIdx;
    logic [7:0]         w_nextShift;
    logic               w_nextSerout;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_empty;
    logic               w_canStart;

    // FIFO status comes only from the registered count, so a pop on the
    // same edge never frees room for a write while full.
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = host_wr & ~w_full;
    assign w_canStart = ~w_empty & r_ctsSync;

    assign host_dir = ~w_full;
    assign serout   = r_serout;
    assign busy     = (r_state != IDLE) | ~w_empty;

    // Two-flop synchroniser for the far-end clear-to-send input.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ctsMeta <= 1'b0;
            r_ctsSync <= 1'b0;
        end else begin
            r_ctsMeta <= cts;
            r_ctsSync <= r_ctsMeta;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count
    // define what is valid.
    always_ff @(negedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= host_din;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the
    // power-of-two depth.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame state register, including the registered serial output.
    always_ff @(negedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= IDLE;
            r_tick   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_serout <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_tick   <= w_nextTick;
            r_bitIdx <= w_nextBitIdx;
            r_shift  <= w_nextShift;
            r_serout <= w_nextSerout;
        end
    end

    // Next-state logic: each phase lasts whole bit periods, and the end of
    // the stop period may launch the next frame directly to avoid a gap.
    always_comb begin
        w_nextState  = r_state;
        w_nextTick   = r_tick;
        w_nextBitIdx = r_bitIdx;
        w_nextShift  = r_shift;
        w_nextSerout = r_serout;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextSerout = 1'b1;
                if (w_canStart) begin
                    w_pop        = 1'b1;
                    w_nextShift  = r_mem[r_rdPtr];
                    w_nextSerout = 1'b0;
                    w_nextTick   = '0;
                    w_nextState  = START;
                end
            end

            START: begin
                if (r_tick == BIT_LAST) begin
                    w_nextSerout = r_shift[0];
                    w_nextBitIdx = '0;
                    w_nextTick   = '0;
                    w_nextState  = BIT;
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end

            BIT: begin
                if (r_tick == BIT_LAST) begin
                    w_nextTick  = '0;
                    w_nextShift = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_nextSerout = 1'b1;
                        w_nextState  = STOP;
                    end else begin
                        w_nextSerout = r_shift[1];
                        w_nextBitIdx = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end

            STOP: begin
                if (r_tick == STOP_LAST) begin
                    w_nextTick = '0;
                    if (w_canStart) begin
                        w_pop        = 1'b1;
                        w_nextShift  = r_mem[r_rdPtr];
                        w_nextSerout = 1'b0;
                        w_nextState  = START;
                    end else begin
                        w_nextSerout = 1'b1;
                        w_nextState  = IDLE;
                    end
                end else begin
                    w_nextTick = r_tick + TICK_W'(1);
                end
            end

            default: begin
                w_nextState  = IDLE;
                w_nextSerout = 1'b1;
                w_nextTick   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Writes are modelled at the
// byte level; a line monitor decodes frames from serout and compares them
// against the queue of bytes the host model believes were accepted.
module tb_uart_tx;

   localparam int T     = 16;
   localparam int DEPTH = 4;

   logic       clk;
   logic       reset_b;
   logic [7:0] hostDin;
   logic       hostWr;
   logic       hostDir;
   logic       cts;
   logic       serout;
   logic       busy;

   logic [7:0] hostDin2;
   logic       hostWr2;
   logic       hostDir2;
   logic       cts2;
   logic       serout2;
   logic       busy2;

   int passCount  = 0;
   int checkCount = 0;
   int edgeCount  = 0;

   int startsSeen [2];
   int framesDone [2];
   int accepted   [2];

   logic [7:0] expQ0 [$];
   logic [7:0] expQ1 [$];
   int         startQ0 [$];
   int         startQ1 [$];

   uart_tx #(.TICKS_PER_BIT(T), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
      .clk      (clk),
      .reset_b  (reset_b),
      .host_din (hostDin),
      .host_wr  (hostWr),
      .host_dir (hostDir),
      .cts      (cts),
      .serout   (serout),
      .busy     (busy)
   );

   uart_tx #(.TICKS_PER_BIT(T), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
      .clk      (clk),
      .reset_b  (reset_b),
      .host_din (hostDin2),
      .host_wr  (hostWr2),
      .host_dir (hostDir2),
      .cts      (cts2),
      .serout   (serout2),
      .busy     (busy2)
   );

   // Free-running clock; the design acts on falling edges.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Falling-edge index used to express timing in design edges.
   always @(negedge clk) edgeCount <= edgeCount + 1;

   // Hard stop in case something never terminates.
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic lineOf(input int w);
      return (w == 0) ? serout : serout2;
   endfunction

   function automatic logic busyOf(input int w);
      return (w == 0) ? busy : busy2;
   endfunction

   function automatic logic dirOf(input int w);
      return (w == 0) ? hostDir : hostDir2;
   endfunction

   // Expected line level k edges after the write edge of a lone frame.
   function automatic logic refLevel(input logic [7:0] data, input int k);
      int idx;
      if (k < 1) return 1'b1;
      idx = (k - 1) / T;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return data[idx-1];
      return 1'b1;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
   endtask

   task automatic setBus(input int w, input logic wr, input logic [7:0] din);
      if (w == 0) begin
         hostWr  = wr;
         hostDin = din;
      end else begin
         hostWr2  = wr;
         hostDin2 = din;
      end
   endtask

   // One host cycle: check readiness against the occupancy model, drive
   // the strobe, and record the byte if the model says it is accepted.
   task automatic applyStimulus(input int w, input logic wr, input logic [7:0] din, output int wrEdge);
      int   occ;
      logic expDir;
      @(posedge clk);
      #1;
      occ    = accepted[w] - startsSeen[w];
      expDir = (occ < DEPTH);
      checkOutput((w == 0) ? "hostDir" : "hostDir2", int'(dirOf(w)), int'(expDir));
      setBus(w, wr, din);
      if (wr && expDir) begin
         if (w == 0) expQ0.push_back(din);
         else expQ1.push_back(din);
         accepted[w]++;
      end
      wrEdge = edgeCount + 1;
   endtask

   task automatic idleCycles(input int w, input int n);
      int dummy;
      for (int i = 0; i < n; i++) applyStimulus(w, 1'b0, 8'h00, dummy);
   endtask

   task automatic waitFrames(input int w, input int target, input int budget);
      int n;
      n = 0;
      while (framesDone[w] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (framesDone[w] < target) checkOutput("waitFrames timeout", framesDone[w], target);
   endtask

   task automatic waitStarts(input int w, input int target, input int budget);
      int n;
      n = 0;
      while (startsSeen[w] < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (startsSeen[w] < target) checkOutput("waitStarts timeout", startsSeen[w], target);
   endtask

   task automatic waitEdge(input int target);
      while (edgeCount < target) @(posedge clk);
      #1;
   endtask

   function automatic int startAt(input int w, input int idx);
      if (w == 0) return (idx < startQ0.size()) ? startQ0[idx] : -1;
      return (idx < startQ1.size()) ? startQ1[idx] : -1;
   endfunction

   // Write one byte and check the whole line/busy profile edge by edge.
   task automatic profileCheck(input int w, input logic [7:0] data, input int stops);
      int e0;
      int frameLen;
      frameLen = (9 + stops) * T;
      applyStimulus(w, 1'b1, data, e0);
      for (int k = 0; k <= frameLen + 3; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) setBus(w, 1'b0, 8'h00);
         checkOutput($sformatf("level%0d k=%0d", w, k), int'(lineOf(w)), int'(refLevel(data, k)));
         checkOutput($sformatf("busy%0d k=%0d", w, k), int'(busyOf(w)), int'(k <= frameLen));
      end
   endtask

   // Frame decoder: every bit must hold for exactly T samples and the stop
   // period for stops*T samples; reset during a frame discards it.
   task automatic monitorLine(input int w, input int stops);
      logic [7:0] data;
      logic [7:0] expByte;
      logic       lvl;
      bit         bad;
      bit         aborted;
      forever begin
         @(posedge clk);
         if (reset_b && lineOf(w) == 1'b0) begin
            bad     = 1'b0;
            aborted = 1'b0;
            data    = 8'h00;
            startsSeen[w]++;
            if (w == 0) startQ0.push_back(edgeCount);
            else startQ1.push_back(edgeCount);
            for (int i = 1; i < T; i++) begin
               @(posedge clk);
               if (!reset_b) aborted = 1'b1;
               else if (lineOf(w) !== 1'b0) bad = 1'b1;
            end
            for (int b = 0; b < 8; b++) begin
               @(posedge clk);
               if (!reset_b) aborted = 1'b1;
               lvl     = lineOf(w);
               data[b] = lvl;
               for (int i = 1; i < T; i++) begin
                  @(posedge clk);
                  if (!reset_b) aborted = 1'b1;
                  else if (lineOf(w) !== lvl) bad = 1'b1;
               end
            end
            for (int i = 0; i < stops * T; i++) begin
               @(posedge clk);
               if (!reset_b) aborted = 1'b1;
               else if (lineOf(w) !== 1'b1) bad = 1'b1;
            end
            if (!aborted) begin
               checkOutput((w == 0) ? "frameTiming" : "frameTiming2", int'(bad), 0);
               if ((w == 0 && expQ0.size() == 0) || (w == 1 && expQ1.size() == 0)) begin
                  checkOutput((w == 0) ? "unexpectedFrame" : "unexpectedFrame2", 1, 0);
               end else begin
                  expByte = (w == 0) ? expQ0.pop_front() : expQ1.pop_front();
                  checkOutput((w == 0) ? "frameByte" : "frameByte2", int'(data), int'(expByte));
               end
               framesDone[w]++;
            end
         end
      end
   endtask

   initial monitorLine(0, 1);
   initial monitorLine(1, 2);

   initial begin
      int e0;
      int n0;
      int f0;
      int s0;
      int riseEdge;
      int budget;

      for (int i = 0; i < 2; i++) begin
         startsSeen[i] = 0;
         framesDone[i] = 0;
         accepted[i]   = 0;
      end
      reset_b  = 1'b0;
      cts      = 1'b1;
      cts2     = 1'b1;
      hostWr   = 1'b0;
      hostDin  = 8'h00;
      hostWr2  = 1'b0;
      hostDin2 = 8'h00;

      // Reset values while reset_b is held low.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetSerout", int'(serout), 1);
      checkOutput("resetHostDir", int'(hostDir), 1);
      checkOutput("resetBusy", int'(busy), 0);
      checkOutput("resetSerout2", int'(serout2), 1);
      reset_b = 1'b1;
      idleCycles(0, 5);

      // Single 0xA5 frame: exact latency, bit order and busy release.
      $display("[TB] lone 0xA5 frame");
      profileCheck(0, 8'hA5, 1);
      waitFrames(0, 1, 400);

      // Three back-to-back frames with no idle edge between them.
      $display("[TB] back-to-back frames");
      n0 = startsSeen[0];
      f0 = framesDone[0];
      applyStimulus(0, 1'b1, 8'h00, e0);
      applyStimulus(0, 1'b1, 8'hFF, s0);
      applyStimulus(0, 1'b1, 8'h3C, s0);
      idleCycles(0, 2);
      waitFrames(0, f0 + 3, 800);
      checkOutput("firstStartLatency", startAt(0, n0), e0 + 1);
      checkOutput("gap1", startAt(0, n0 + 1) - startAt(0, n0), 10 * T);
      checkOutput("gap2", startAt(0, n0 + 2) - startAt(0, n0 + 1), 10 * T);
      idleCycles(0, 20);

      // cts low: fill the FIFO, fifth write must be ignored.
      $display("[TB] overflow with cts low");
      cts = 1'b0;
      idleCycles(0, 4);
      n0 = startsSeen[0];
      f0 = framesDone[0];
      for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 8'($urandom_range(0, 255)), s0);
      idleCycles(0, 40);
      checkOutput("hostDirFullHold", int'(hostDir), 0);
      checkOutput("noStartWhileCtsLow", startsSeen[0], n0);
      @(posedge clk);
      #1;
      cts = 1'b1;
      riseEdge = edgeCount;
      waitFrames(0, f0 + 4, 1000);
      checkOutput("ctsRiseLatency", startAt(0, n0), riseEdge + 3);
      idleCycles(0, 250);
      checkOutput("exactlyFourFrames", framesDone[0] - f0, 4);
      checkOutput("busyAfterFour", int'(busy), 0);

      // cts dropped during bit 3 of 0x55 holds the next byte only.
      $display("[TB] cts drop mid-frame");
      n0 = startsSeen[0];
      f0 = framesDone[0];
      applyStimulus(0, 1'b1, 8'h55, s0);
      applyStimulus(0, 1'b1, 8'($urandom_range(0, 255)), s0);
      idleCycles(0, 1);
      waitStarts(0, n0 + 1, 50);
      waitEdge(startAt(0, n0) + 4 * T + 6);
      cts = 1'b0;
      waitFrames(0, f0 + 1, 300);
      idleCycles(0, 100);
      checkOutput("heldWhileCtsLow", startsSeen[0], n0 + 1);
      @(posedge clk);
      #1;
      cts = 1'b1;
      riseEdge = edgeCount;
      waitFrames(0, f0 + 2, 400);
      checkOutput("resumeLatency", startAt(0, n0 + 1), riseEdge + 3);
      idleCycles(0, 20);

      // Reset during bit 5 with two bytes still queued.
      $display("[TB] reset mid-frame");
      n0 = startsSeen[0];
      applyStimulus(0, 1'b1, 8'h0F, s0);
      applyStimulus(0, 1'b1, 8'($urandom_range(0, 255)), s0);
      applyStimulus(0, 1'b1, 8'($urandom_range(0, 255)), s0);
      idleCycles(0, 1);
      waitStarts(0, n0 + 1, 50);
      waitEdge(startAt(0, n0) + 6 * T + 4);
      checkOutput("bit5Low", int'(serout), 0);
      reset_b = 1'b0;
      #1;
      checkOutput("seroutOnReset", int'(serout), 1);
      expQ0.delete();
      accepted[0] = startsSeen[0];
      repeat (2) @(posedge clk);
      #1;
      reset_b = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("hostDirAfterReset", int'(hostDir), 1);
      checkOutput("busyAfterReset", int'(busy), 0);
      idleCycles(0, 300);
      checkOutput("noFrameAfterReset", startsSeen[0], n0 + 1);

      // Two stop bits: 0x81 must give a 176-edge frame.
      $display("[TB] two stop bits");
      profileCheck(1, 8'h81, 2);
      waitFrames(1, 1, 400);

      // Randomised traffic with random cts toggling.
      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) == 0) cts = ~cts;
         applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), s0);
      end
      setBus(0, 1'b0, 8'h00);
      cts = 1'b1;
      budget = 0;
      while (expQ0.size() != 0 && budget < 3000) begin
         @(posedge clk);
         budget++;
      end
      checkOutput("drainComplete", expQ0.size(), 0);
      idleCycles(0, 200);
      checkOutput("busyAfterDrain", int'(busy), 0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
